// File: rtl/cpu_types_pkg.sv
// Shared data-cache types: address fields, cache frame layout and controller states.
// DCACHE_HITCNT_EN adds the HITCNT state used to write the hit count out at flush.
package cpu_types_pkg;

    localparam int DC_SETS = 8;
    localparam int DC_WAYS = 2;

    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcachef_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [25:0]      tag;
        logic [1:0][31:0] data;
    } dframe_t;

    typedef enum logic [3:0] {
        IDLE,
        WB1,
        WB2,
        FETCH1,
        FETCH2,
        FLUSH1,
        FLUSH2,
`ifdef DCACHE_HITCNT_EN
        HITCNT,
`endif
        DONE
    } dstate_t;

    function automatic logic [31:0] word_addr(input logic [25:0] tag,
                                              input logic [2:0]  idx,
                                              input logic        off);
        return {tag, idx, off, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// 8-set x 2-way frame storage with one LRU bit per set.
// Reads are combinational on idx; frame and LRU writes land on the rising edge.
module dcache_array
    import cpu_types_pkg::*;
(
    input  logic    CLK,
    input  logic    nRST,
    input  logic [2:0] idx,
    output dframe_t frame0,
    output dframe_t frame1,
    output logic    lru,
    input  logic    wr_en,
    input  logic    wr_way,
    input  dframe_t wr_frame,
    input  logic    lru_en,
    input  logic    lru_val
);

    dframe_t            frames [DC_SETS][DC_WAYS];
    logic [DC_SETS-1:0] lru_bits;

    assign frame0 = frames[idx][0];
    assign frame1 = frames[idx][1];
    assign lru    = lru_bits[idx];

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            for (int s = 0; s < DC_SETS; s++) begin
                for (int w = 0; w < DC_WAYS; w++) begin
                    frames[s][w] <= '0;
                end
            end
            lru_bits <= '0;
        end else begin
            if (wr_en) begin
                frames[idx][wr_way] <= wr_frame;
            end
            if (lru_en) begin
                lru_bits[idx] <= lru_val;
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// 2-way write-back, write-allocate data cache controller with halt-triggered flush.
// Define DCACHE_HITCNT_EN to count hit cycles and write the count to HITCNT_ADDR after flush.
module dcache_controller
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] HITCNT_ADDR = 32'h00003100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    dstate_t     state, next_state;
    dcachef_t    addr;
    dframe_t     frame0, frame1, sel_frame, hit_frame, wr_frame;
    logic        lru, victim, next_victim, sel_way, flushing;
    logic        hit0, hit1, req, flush_step;
    logic        wr_en, wr_way, lru_en, lru_val;
    logic [3:0]  flush_cnt, next_flush_cnt;
    logic [31:0] fetch_word, next_fetch_word;
    logic [2:0]  idx;
    logic        unused_bytoff;

    assign addr          = dmemaddr;
    assign unused_bytoff = ^addr.bytoff;
    assign flushing      = (state == FLUSH1) || (state == FLUSH2);
    assign idx           = flushing ? flush_cnt[3:1] : addr.idx;
    assign sel_way       = flushing ? flush_cnt[0] : victim;
    assign sel_frame     = sel_way ? frame1 : frame0;
    assign req           = dmemREN | dmemWEN;
    assign hit0          = frame0.valid && (frame0.tag == addr.tag);
    assign hit1          = frame1.valid && (frame1.tag == addr.tag);
    assign hit_frame     = hit0 ? frame0 : frame1;

    dcache_array u_array (
        .CLK      (CLK),
        .nRST     (nRST),
        .idx      (idx),
        .frame0   (frame0),
        .frame1   (frame1),
        .lru      (lru),
        .wr_en    (wr_en),
        .wr_way   (wr_way),
        .wr_frame (wr_frame),
        .lru_en   (lru_en),
        .lru_val  (lru_val)
    );

`ifdef DCACHE_HITCNT_EN
    logic [31:0] hit_count;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            hit_count <= '0;
        end else if (dhit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
        end
    end
`else
    logic [31:0] unused_hitcnt_addr;
    assign unused_hitcnt_addr = HITCNT_ADDR;
`endif

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state      <= IDLE;
            victim     <= 1'b0;
            flush_cnt  <= '0;
            fetch_word <= '0;
        end else begin
            state      <= next_state;
            victim     <= next_victim;
            flush_cnt  <= next_flush_cnt;
            fetch_word <= next_fetch_word;
        end
    end

    always_comb begin
        next_state      = state;
        next_victim     = victim;
        next_flush_cnt  = flush_cnt;
        next_fetch_word = fetch_word;
        dhit            = 1'b0;
        dmemload        = '0;
        dREN            = 1'b0;
        dWEN            = 1'b0;
        daddr           = '0;
        dstore          = '0;
        flushed         = 1'b0;
        wr_en           = 1'b0;
        wr_way          = sel_way;
        wr_frame        = sel_frame;
        lru_en          = 1'b0;
        lru_val         = lru;
        flush_step      = 1'b0;

        case (state)
            IDLE: begin
                // A hit completes even in the cycle halt arrives; a miss defers to the flush.
                if (req && (hit0 || hit1)) begin
                    dhit     = 1'b1;
                    dmemload = hit_frame.data[addr.blkoff];
                    lru_en   = 1'b1;
                    lru_val  = hit0;
                    if (dmemWEN) begin
                        wr_en    = 1'b1;
                        wr_way   = ~hit0;
                        wr_frame = hit_frame;
                        wr_frame.dirty = 1'b1;
                        wr_frame.data[addr.blkoff] = dmemstore;
                    end
                end
                if (halt) begin
                    next_state     = FLUSH1;
                    next_flush_cnt = '0;
                end else if (req && !(hit0 || hit1)) begin
                    next_victim = lru;
                    if (lru ? (frame1.valid && frame1.dirty) : (frame0.valid && frame0.dirty)) begin
                        next_state = WB1;
                    end else begin
                        next_state = FETCH1;
                    end
                end
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = word_addr(sel_frame.tag, addr.idx, 1'b0);
                dstore = sel_frame.data[0];
                if (!dwait) next_state = WB2;
            end
            WB2: begin
                dWEN   = 1'b1;
                daddr  = word_addr(sel_frame.tag, addr.idx, 1'b1);
                dstore = sel_frame.data[1];
                if (!dwait) next_state = FETCH1;
            end
            FETCH1: begin
                dREN  = 1'b1;
                daddr = word_addr(addr.tag, addr.idx, 1'b0);
                if (!dwait) begin
                    next_fetch_word = dload;
                    next_state      = FETCH2;
                end
            end
            FETCH2: begin
                dREN  = 1'b1;
                daddr = word_addr(addr.tag, addr.idx, 1'b1);
                if (!dwait) begin
                    wr_en      = 1'b1;
                    wr_way     = victim;
                    wr_frame   = '{valid: 1'b1, dirty: 1'b0, tag: addr.tag, data: {dload, fetch_word}};
                    next_state = IDLE;
                end
            end
            FLUSH1: begin
                if (sel_frame.valid && sel_frame.dirty) begin
                    dWEN   = 1'b1;
                    daddr  = word_addr(sel_frame.tag, flush_cnt[3:1], 1'b0);
                    dstore = sel_frame.data[0];
                    if (!dwait) next_state = FLUSH2;
                end else begin
                    flush_step = 1'b1;
                end
            end
            FLUSH2: begin
                dWEN   = 1'b1;
                daddr  = word_addr(sel_frame.tag, flush_cnt[3:1], 1'b1);
                dstore = sel_frame.data[1];
                if (!dwait) flush_step = 1'b1;
            end
`ifdef DCACHE_HITCNT_EN
            HITCNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hit_count;
                if (!dwait) next_state = DONE;
            end
`endif
            DONE: begin
                flushed = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Leaving a flush frame always invalidates it, whether or not it was written back.
        if (flush_step) begin
            wr_en          = 1'b1;
            wr_way         = flush_cnt[0];
            wr_frame       = sel_frame;
            wr_frame.valid = 1'b0;
            wr_frame.dirty = 1'b0;
            if (flush_cnt == 4'd15) begin
`ifdef DCACHE_HITCNT_EN
                next_state = HITCNT;
`else
                next_state = DONE;
`endif
            end else begin
                next_flush_cnt = flush_cnt + 4'd1;
                next_state     = FLUSH1;
            end
        end
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter HITCNT_ADDR, default 32'h00003100, meaning the word address the hit counter is written to during flush.
REQ-002 SHALL have port CLK  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port halt  input  1  datapath halt request, starts flush.
REQ-005 SHALL have port dmemREN/dmemWEN  input  1 each  datapath read/write request.
REQ-006 SHALL have port dmemaddr  input  32  byte address; tag [31:6], index [5:3], block offset [2], byte [1:0] ignored.
REQ-007 SHALL have port dmemstore  input  32  write data; dmemload  output  32  read data.
REQ-008 SHALL have port dhit  output  1  request completes this cycle.
REQ-009 SHALL have port flushed  output  1  flush complete, sticky until reset.
REQ-010 SHALL have ports dREN, dWEN  output  1 each; daddr, dstore  output  32; dload  input  32; dwait  input  1 -- the memory-controller side.

Function
REQ-011 SHALL be 2-way set associative, 8 sets, 2-word blocks, write-back, write-allocate; per frame valid, dirty, 26-bit tag; per set one LRU bit.
REQ-012 SHALL assert dhit combinationally when (dmemREN|dmemWEN) in IDLE and a valid way's tag matches; dmemload = matching word, else 0.
REQ-013 On read hit SHALL set set-LRU to the other way at the clock edge; on write hit SHALL store the word, set dirty, update LRU.
REQ-014 dmemWEN SHALL take priority when both dmemREN and dmemWEN are high.
REQ-015 States: IDLE, WB1, WB2, FETCH1, FETCH2, FLUSH1, FLUSH2, HITCNT, DONE.
REQ-016 Miss in IDLE: victim = LRU way; victim valid&dirty -> WB1, else -> FETCH1.
REQ-017 WB1/WB2 SHALL drive dWEN, daddr = {victim tag, index, offset 0/1, 2'b00}, dstore = victim word 0/1; advance when dwait low; WB2 -> FETCH1.
REQ-018 FETCH1/FETCH2 SHALL drive dREN, daddr = {request tag, index, 0/1, 2'b00}; capture dload when dwait low; FETCH2 exit installs tag, valid=1, dirty=0 and returns to IDLE, where the retried request hits.
REQ-019 dREN and dWEN SHALL never be high together; both low in IDLE and DONE.
REQ-020 halt in IDLE (no miss in progress) SHALL start flush with frame counter 0; halt during a miss SHALL be honoured after return to IDLE.
REQ-021 Flush SHALL visit frames 0..15 (set = counter[3:1], way = counter[0]); dirty frames written via FLUSH1/FLUSH2 (same addressing as WB), clean frames skipped in one cycle; each visited frame invalidated.
REQ-022 After frame 15, SHALL go to HITCNT (macro defined) or DONE; DONE asserts flushed and ignores all requests, dhit=0.
REQ-023 Hit counter SHALL be 32-bit, count cycles with dhit=1, saturate at 32'hFFFFFFFF.

Reset
REQ-024 nRST high SHALL immediately clear all valid, dirty, LRU bits, frame counter, hit counter; state IDLE; dREN=dWEN=flushed=dhit=0, daddr=dstore=0; applies mid-miss and mid-flush.

Configuration
REQ-025 With DCACHE_HITCNT_EN defined, HITCNT SHALL drive dWEN, daddr=HITCNT_ADDR, dstore=hit count until dwait low, then DONE.
REQ-026 Without DCACHE_HITCNT_EN, counter logic and HITCNT state SHALL be absent; flush goes straight to DONE.

Structure
REQ-027 Frame struct (valid, dirty, tag, 2 data words), address-field struct, and state enum SHALL live in the shared cpu_types_pkg.
REQ-028 The 8x2 frame array with LRU SHALL be sub-module dcache_array (read combinational, write synchronous).

Verification
REQ-029 Cold read 0x40, dload 0xAAAA/0xBBBB with dwait low each cycle -> FETCH1 daddr 0x40, FETCH2 daddr 0x44, then dhit, dmemload 0xAAAA.
REQ-030 Write 0x44=0x1234 after fill -> dhit same cycle; later read 0x44 -> dmemload 0x1234.
REQ-031 Dirty 0x40 and 0x80 fill set 0; read 0xC0 -> WB1 daddr 0x40 (LRU way), WB2 0x44, FETCH1 0xC0.
REQ-032 Halt with two dirty frames -> exactly 4 dWEN transactions, then (EN) write to 0x3100 with hit count, flushed=1 thereafter.
REQ-033 nRST high during FETCH2 with dwait high -> outputs zero immediately; read of same address afterwards misses.
REQ-034 dwait held high 5 cycles in WB1 -> daddr/dstore stable, no state advance until dwait low.
